sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/traffic_pkg.sv | 19 +
 rtl/sensor_debounce.sv | 52 +++++
 rtl/sensor_conditioner.sv | 113 +++++++++++
 tb/tb_sensor_conditioner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and defaults for the level-crossing sensor path.
// Holds the train FSM state encoding and counter sizing helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_ACTIVE = 2'd1,
    T_HOLD   = 2'd2
  } train_state_t;

  localparam int DEFAULT_DEBOUNCE   = 4;
  localparam int DEFAULT_TRAIN_HOLD = 8;

  // Bits needed to count 0..n, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// 2-flop synchronizer plus debounce filter; level follows raw after 2+DEBOUNCE edges.
// No backpressure: free-running, one sample per clk.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_toggle
);

  localparam int              CW   = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_toggle;

  assign w_differ = (r_sync2 != r_level);
  assign w_toggle = w_differ && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any agreement restarts qualification, so short glitches never accumulate.
      if (!w_differ || w_toggle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_toggle) begin
        r_level <= ~r_level;
      end
    end
  end

  assign o_level  = r_level;
  assign o_toggle = w_toggle;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions raw train/vehicle sensors; train channel adds a TRAIN_HOLD clearance hold.
// Latency 2+DEBOUNCE edges raw->output; no backpressure, outputs registered.
module sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE   = DEFAULT_DEBOUNCE,
  parameter int TRAIN_HOLD = DEFAULT_TRAIN_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_train,
  input  logic raw_sub_highway,
  output logic sen_train,
  output logic sen_sub_highway,
  output logic hold_active
);

  localparam int            HW        = cnt_width(TRAIN_HOLD);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(TRAIN_HOLD);

  logic         w_train_lvl;
  logic         w_train_tog;
  logic         w_sub_lvl;
  logic         w_sub_tog;
  logic         w_train_rise;
  logic         w_train_fall;
  logic         w_sub_nxt;

  train_state_t  r_state;
  logic [HW-1:0] r_hold_cnt;
  logic          r_sen_train;
  logic          r_sen_sub;
  logic          r_hold_active;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_train (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_raw    (raw_train),
    .o_level  (w_train_lvl),
    .o_toggle (w_train_tog)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_sub (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_raw    (raw_sub_highway),
    .o_level  (w_sub_lvl),
    .o_toggle (w_sub_tog)
  );

  // FSM reacts to the toggle itself so outputs move on the same edge as the debounced level.
  assign w_train_rise = w_train_tog && !w_train_lvl;
  assign w_train_fall = w_train_tog &&  w_train_lvl;
  assign w_sub_nxt    = w_sub_lvl ^ w_sub_tog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= T_IDLE;
      r_hold_cnt    <= '0;
      r_sen_train   <= 1'b0;
      r_sen_sub     <= 1'b0;
      r_hold_active <= 1'b0;
    end else begin
      r_sen_sub <= w_sub_nxt;
      case (r_state)
        T_IDLE: begin
          if (w_train_rise) begin
            r_state     <= T_ACTIVE;
            r_sen_train <= 1'b1;
          end
        end
        T_ACTIVE: begin
          if (w_train_fall) begin
            if (TRAIN_HOLD > 0) begin
              r_state       <= T_HOLD;
              r_hold_cnt    <= HOLD_LOAD;
              r_hold_active <= 1'b1;
            end else begin
              r_state     <= T_IDLE;
              r_sen_train <= 1'b0;
            end
          end
        end
        T_HOLD: begin
          // A returning train wins over an expiring hold in the same cycle.
          if (w_train_rise) begin
            r_state       <= T_ACTIVE;
            r_hold_cnt    <= '0;
            r_hold_active <= 1'b0;
          end else if (r_hold_cnt == HW'(1)) begin
            r_state       <= T_IDLE;
            r_hold_cnt    <= '0;
            r_sen_train   <= 1'b0;
            r_hold_active <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HW'(1);
          end
        end
        default: begin
          r_state       <= T_IDLE;
          r_hold_cnt    <= '0;
          r_sen_train   <= 1'b0;
          r_hold_active <= 1'b0;
        end
      endcase
    end
  end

  assign sen_train       = r_sen_train;
  assign sen_sub_highway = r_sen_sub;
  assign hold_active     = r_hold_active;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench: expected output edges queued at stimulus time, matched as outputs change.
module tb_sensor_conditioner;

  localparam int S_TRAIN = 0, S_SUB = 1, S_HOLD = 2, S_ZTRAIN = 3, S_ZHOLD = 4, S_ZSUB = 5;

  logic clk;
  logic rst;
  logic raw_train;
  logic raw_sub_highway;
  logic sen_train, sen_sub_highway, hold_active;
  logic z_sen_train, z_sen_sub, z_hold;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int    sig;
    int    val;
    int    cyc;
    string tag;
  } evt_t;

  evt_t sb[$];
  logic [5:0] prev = '0;

  sensor_conditioner #(.DEBOUNCE(4), .TRAIN_HOLD(8)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .raw_train       (raw_train),
    .raw_sub_highway (raw_sub_highway),
    .sen_train       (sen_train),
    .sen_sub_highway (sen_sub_highway),
    .hold_active     (hold_active)
  );

  sensor_conditioner #(.DEBOUNCE(4), .TRAIN_HOLD(0)) u_dut_nohold (
    .clk             (clk),
    .rst             (rst),
    .raw_train       (raw_train),
    .raw_sub_highway (raw_sub_highway),
    .sen_train       (z_sen_train),
    .sen_sub_highway (z_sen_sub),
    .hold_active     (z_hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_evt(input int sig, input int val, input int c, input string tag);
    evt_t e;
    e.sig = sig;
    e.val = val;
    e.cyc = c;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic match(input int sig, input int cur, input int old);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].sig == sig) idx = i;
    end
    if (idx < 0) begin
      chk($sformatf("unexpected_change_sig%0d_cyc%0d", sig, cyc), cur, old);
    end else begin
      chk({sb[idx].tag, "_cycle"}, cyc, sb[idx].cyc);
      chk({sb[idx].tag, "_value"}, cur, sb[idx].val);
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] cur;
    cur = {z_sen_sub, z_hold, z_sen_train, hold_active, sen_sub_highway, sen_train};
    if (mon_en) begin
      for (int s = 0; s < 6; s++) begin
        if (cur[s] !== prev[s]) match(s, int'(cur[s]), int'(prev[s]));
      end
    end
    prev = cur;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    while (sb.size() != 0) begin
      chk({"missing_", sb[0].tag}, -1, sb[0].cyc);
      sb.delete(0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, m;
    rst = 1'b0;
    raw_train = 1'b0;
    raw_sub_highway = 1'b0;

    // Reset state
    #12;
    chk("rst_sen_train", sen_train, 0);
    chk("rst_sen_sub", sen_sub_highway, 0);
    chk("rst_hold", hold_active, 0);
    chk("rst_z_sen_train", z_sen_train, 0);
    chk("rst_z_sen_sub", z_sen_sub, 0);
    chk("rst_z_hold", z_hold, 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    wait_cyc(2);

    // Sub-highway held high then low
    n = cyc;
    raw_sub_highway = 1'b1;
    expect_evt(S_SUB, 1, n + 6, "sub_rise");
    expect_evt(S_ZSUB, 1, n + 6, "zsub_rise");
    wait_cyc(10);
    n = cyc;
    raw_sub_highway = 1'b0;
    expect_evt(S_SUB, 0, n + 6, "sub_fall");
    expect_evt(S_ZSUB, 0, n + 6, "zsub_fall");
    wait_cyc(10);
    drain(4);

    // 3-cycle pulses rejected on both channels
    raw_sub_highway = 1'b1;
    wait_cyc(3);
    raw_sub_highway = 1'b0;
    wait_cyc(4);
    raw_train = 1'b1;
    wait_cyc(3);
    raw_train = 1'b0;
    wait_cyc(12);

    // Exactly DEBOUNCE-cycle pulse is accepted
    n = cyc;
    raw_sub_highway = 1'b1;
    expect_evt(S_SUB, 1, n + 6, "pulse4_rise");
    expect_evt(S_ZSUB, 1, n + 6, "zpulse4_rise");
    expect_evt(S_SUB, 0, n + 10, "pulse4_fall");
    expect_evt(S_ZSUB, 0, n + 10, "zpulse4_fall");
    wait_cyc(4);
    raw_sub_highway = 1'b0;
    wait_cyc(12);
    drain(4);

    // Train 20 cycles then release: 8-cycle hold, no-hold build drops at once
    n = cyc;
    raw_train = 1'b1;
    expect_evt(S_TRAIN, 1, n + 6, "train_rise");
    expect_evt(S_ZTRAIN, 1, n + 6, "ztrain_rise");
    wait_cyc(20);
    m = cyc;
    raw_train = 1'b0;
    expect_evt(S_HOLD, 1, m + 6, "hold_rise");
    expect_evt(S_HOLD, 0, m + 14, "hold_fall");
    expect_evt(S_TRAIN, 0, m + 14, "train_fall");
    expect_evt(S_ZTRAIN, 0, m + 6, "ztrain_fall");
    wait_cyc(20);
    drain(4);

    // Retrigger mid-hold, then on the expiry cycle itself
    for (int k = 0; k < 2; k++) begin
      n = cyc;
      raw_train = 1'b1;
      expect_evt(S_TRAIN, 1, n + 6, $sformatf("rt%0d_train_rise", k));
      expect_evt(S_ZTRAIN, 1, n + 6, $sformatf("rt%0d_ztrain_rise", k));
      wait_cyc(12);
      m = cyc;
      raw_train = 1'b0;
      expect_evt(S_HOLD, 1, m + 6, $sformatf("rt%0d_hold_rise", k));
      expect_evt(S_ZTRAIN, 0, m + 6, $sformatf("rt%0d_ztrain_fall", k));
      wait_cyc(k == 0 ? 5 : 8);
      raw_train = 1'b1;
      expect_evt(S_HOLD, 0, m + (k == 0 ? 11 : 14), $sformatf("rt%0d_hold_cancel", k));
      expect_evt(S_ZTRAIN, 1, m + (k == 0 ? 11 : 14), $sformatf("rt%0d_ztrain_rerise", k));
      wait_cyc(12);
      drain(4);
      // Back in T_ACTIVE: a release produces a full hold again
      m = cyc;
      raw_train = 1'b0;
      expect_evt(S_HOLD, 1, m + 6, $sformatf("rt%0d_hold2_rise", k));
      expect_evt(S_HOLD, 0, m + 14, $sformatf("rt%0d_hold2_fall", k));
      expect_evt(S_TRAIN, 0, m + 14, $sformatf("rt%0d_train_fall", k));
      expect_evt(S_ZTRAIN, 0, m + 6, $sformatf("rt%0d_ztrain_fall2", k));
      wait_cyc(18);
      drain(4);
    end

    // Both channels on the same edge
    n = cyc;
    raw_train = 1'b1;
    raw_sub_highway = 1'b1;
    expect_evt(S_TRAIN, 1, n + 6, "both_train_rise");
    expect_evt(S_SUB, 1, n + 6, "both_sub_rise");
    expect_evt(S_ZTRAIN, 1, n + 6, "both_ztrain_rise");
    expect_evt(S_ZSUB, 1, n + 6, "both_zsub_rise");
    wait_cyc(12);
    n = cyc;
    raw_train = 1'b0;
    raw_sub_highway = 1'b0;
    expect_evt(S_SUB, 0, n + 6, "both_sub_fall");
    expect_evt(S_ZSUB, 0, n + 6, "both_zsub_fall");
    expect_evt(S_ZTRAIN, 0, n + 6, "both_ztrain_fall");
    expect_evt(S_HOLD, 1, n + 6, "both_hold_rise");
    expect_evt(S_HOLD, 0, n + 14, "both_hold_fall");
    expect_evt(S_TRAIN, 0, n + 14, "both_train_fall");
    wait_cyc(18);
    drain(4);

    // Asynchronous reset in the middle of a hold
    n = cyc;
    raw_train = 1'b1;
    raw_sub_highway = 1'b1;
    expect_evt(S_TRAIN, 1, n + 6, "pre_rst_train_rise");
    expect_evt(S_SUB, 1, n + 6, "pre_rst_sub_rise");
    expect_evt(S_ZTRAIN, 1, n + 6, "pre_rst_ztrain_rise");
    expect_evt(S_ZSUB, 1, n + 6, "pre_rst_zsub_rise");
    wait_cyc(12);
    m = cyc;
    raw_train = 1'b0;
    expect_evt(S_HOLD, 1, m + 6, "pre_rst_hold_rise");
    expect_evt(S_ZTRAIN, 0, m + 6, "pre_rst_ztrain_fall");
    wait_cyc(9);
    drain(2);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_sen_train", sen_train, 0);
    chk("async_rst_hold", hold_active, 0);
    chk("async_rst_sen_sub", sen_sub_highway, 0);
    chk("async_rst_z_sen_sub", z_sen_sub, 0);
    wait_cyc(3);
    // Sub raw stays high through reset and must be re-qualified from scratch
    n = cyc;
    rst = 1'b1;
    raw_train = 1'b1;
    mon_en = 1'b1;
    expect_evt(S_TRAIN, 1, n + 6, "post_rst_train_rise");
    expect_evt(S_ZTRAIN, 1, n + 6, "post_rst_ztrain_rise");
    expect_evt(S_SUB, 1, n + 6, "post_rst_sub_rise");
    expect_evt(S_ZSUB, 1, n + 6, "post_rst_zsub_rise");
    wait_cyc(12);
    drain(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
